// File: rtl/controller_sequencer.sv
// SAP-1 control unit: six-state one-hot ring counter (T1..T6), instruction
// decoder producing the 12-bit control word CON, and a halt latch that
// freezes the machine on HLT until CLR.
//
// CON bit order, bit 11 down to bit 0:
//   {Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar}
module controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic        CLK_bar,
    input  logic        CLR,
    input  logic [3:0]  opcode,
    output logic [11:0] CON,
    output logic [5:0]  T_state,
    output logic        HLT
);

    // One-hot ring encoding: bit0 = T1 .. bit5 = T6.
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    // Control words. NOP leaves every active-low strobe high and every
    // active-high strobe low, so no register loads and nothing drives the bus.
    localparam logic [11:0] CON_NOP      = 12'h3E3;
    localparam logic [11:0] CON_FETCH_T1 = 12'h5E3;  // Ep, Lm_bar: PC -> MAR
    localparam logic [11:0] CON_FETCH_T2 = 12'hBE3;  // Cp: PC increment
    localparam logic [11:0] CON_FETCH_T3 = 12'h263;  // CE_bar, Li_bar: RAM -> IR
    localparam logic [11:0] CON_MEM_ADDR = 12'h1A3;  // Ei_bar, Lm_bar: IR -> MAR
    localparam logic [11:0] CON_LDA_T5   = 12'h2C3;  // CE_bar, La_bar: RAM -> A
    localparam logic [11:0] CON_ARG_T5   = 12'h2E1;  // CE_bar, Lb_bar: RAM -> B
    localparam logic [11:0] CON_ADD_T6   = 12'h3C7;  // Eu, La_bar: A+B -> A
    localparam logic [11:0] CON_SUB_T6   = 12'h3CF;  // Su, Eu, La_bar: A-B -> A
    localparam logic [11:0] CON_OUT_T4   = 12'h3F2;  // Ea, Lo_bar: A -> OUT

    t_state_e t_state_q, t_state_d;
    logic     halted_q,  halted_d;

    // Next-state logic: advance the ring, or latch halt when HLT reaches T4.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        t_state_d = t_state_q;
        halted_d  = halted_q;
        if (!halted_q) begin
            if (t_state_q == T4 && opcode == OP_HLT) begin
                // Ring stays parked at T4 for the whole halted period.
                halted_d = 1'b1;
            end else begin
                unique case (t_state_q)
                    T1:      t_state_d = T2;
                    T2:      t_state_d = T3;
                    T3:      t_state_d = T4;
                    T4:      t_state_d = T5;
                    T5:      t_state_d = T6;
                    T6:      t_state_d = T1;
                    default: t_state_d = T1;  // recover from any illegal pattern
                endcase
            end
        end
    end

    // State registers; CLR dominates, including while halted.
    always_ff @(posedge CLK_bar) begin
        // NOTE: reset is synchronous here, sampled on the clock edge like any
        // other input; non-blocking assignments keep all flops updating
        // together from the values present before the edge.
        if (CLR) begin
            t_state_q <= T1;
            halted_q  <= 1'b0;
        end else begin
            t_state_q <= t_state_d;
            halted_q  <= halted_d;
        end
    end

    // Control-word decode, combinational from ring state, opcode and halt.
    always_comb begin
        CON = CON_NOP;
        if (!halted_q) begin
            unique case (t_state_q)
                T1: CON = CON_FETCH_T1;
                T2: CON = CON_FETCH_T2;
                T3: CON = CON_FETCH_T3;
                T4: begin
                    if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB)
                        CON = CON_MEM_ADDR;
                    else if (opcode == OP_OUT)
                        CON = CON_OUT_T4;
                end
                T5: begin
                    if (opcode == OP_LDA)
                        CON = CON_LDA_T5;
                    else if (opcode == OP_ADD || opcode == OP_SUB)
                        CON = CON_ARG_T5;
                end
                T6: begin
                    if (opcode == OP_ADD)
                        CON = CON_ADD_T6;
                    else if (opcode == OP_SUB)
                        CON = CON_SUB_T6;
                end
                default: CON = CON_NOP;
            endcase
        end
    end

    assign T_state = t_state_q;
    assign HLT     = halted_q;

endmodule
